// File: rtl/rle_encoder.sv
// rtl/rle_encoder.sv - zero-run/value pair encoder for one block of zigzag-ordered coefficients
// Collects N_COEF coefficients, then presents the whole packed pair array until downstream takes it.
module rle_encoder #(
  parameter int N_COEF = 64,
  parameter int VAL_W  = 8,
  parameter int RUN_W  = 6,
  localparam int ENT_W = RUN_W + VAL_W,
  localparam int PTR_W = $clog2(N_COEF + 1),
  localparam int IDX_W = $clog2(N_COEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VAL_W-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ENT_W*N_COEF-1:0]   data_out,
  output logic [PTR_W-1:0]          pair_count
);

  typedef enum logic {COLLECT, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic [RUN_W-1:0]   run;
  logic [PTR_W-1:0]   wr_ptr;
  logic [ENT_W-1:0]   entries [N_COEF];

  logic accept;
  logic handoff;
  logic last_coef;
  logic write_entry;

  assign last_coef   = (idx == IDX_W'(N_COEF - 1));
  // The final coefficient always closes the block with a pair, even if zero.
  assign write_entry = accept && ((in_data != '0) || last_coef);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    handoff    = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && last_coef) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handoff    = 1'b1;
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || handoff) begin
      idx    <= '0;
      run    <= '0;
      wr_ptr <= '0;
      for (int k = 0; k < N_COEF; k++) begin
        entries[k] <= '0;
      end
    end else if (accept) begin
      idx <= idx + IDX_W'(1);
      if (write_entry) begin
        entries[wr_ptr[IDX_W-1:0]] <= {run, in_data};
        wr_ptr <= wr_ptr + PTR_W'(1);
        run    <= '0;
      end else begin
        run <= run + RUN_W'(1);
      end
    end
  end

  assign pair_count = wr_ptr;

  // Entry 0 sits at the MSBs so the decoder can consume from the top down.
  for (genvar k = 0; k < N_COEF; k++) begin : g_pack
    assign data_out[ENT_W*(N_COEF-k)-1 -: ENT_W] = entries[k];
  end

endmodule
